// File: rtl/ysyx_22041461_if_fetch_if.sv
// Bus bundle for the instruction-fetch stage: the instruction-memory read
// channel plus the IF/ID output handshake.
// The optional misalignment flag exists only when IF_MISALIGN_CHECK_EN is defined.
interface ysyx_22041461_if_fetch_if #(
    parameter int XLEN  = 64,
    parameter int BUS_W = 64
);
    logic             imem_req_valid_o;
    logic             imem_req_ready_i;
    logic [XLEN-1:0]  imem_req_addr_o;
    logic             imem_rsp_valid_i;
    logic [BUS_W-1:0] imem_rsp_data_i;
    logic             id_valid_o;
    logic             id_ready_i;
    logic [XLEN-1:0]  id_pc_o;
    logic [31:0]      id_inst_o;
`ifdef IF_MISALIGN_CHECK_EN
    logic             id_misalign_o;
`endif

    // Fetch stage side
    modport master (
        output imem_req_valid_o,
        input  imem_req_ready_i,
        output imem_req_addr_o,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i,
        output id_valid_o,
        input  id_ready_i,
        output id_pc_o,
`ifdef IF_MISALIGN_CHECK_EN
        output id_misalign_o,
`endif
        output id_inst_o
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid_o,
        output imem_req_ready_i,
        input  imem_req_addr_o,
        output imem_rsp_valid_i,
        output imem_rsp_data_i,
        input  id_valid_o,
        output id_ready_i,
        input  id_pc_o,
`ifdef IF_MISALIGN_CHECK_EN
        input  id_misalign_o,
`endif
        input  id_inst_o
    );
endinterface

// File: rtl/ysyx_22041461_if_fetch.sv
// Instruction-fetch stage: single-outstanding read to instruction memory,
// 32-bit instruction selected from the 64-bit beat by pc[2], held in a
// one-entry IF/ID buffer. pc_adv_o pulses once per completed fetch.
// Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned PC yields a nop
// entry flagged by id_misalign_o without touching memory).
module ysyx_22041461_if_fetch #(
    parameter int XLEN  = 64,
    parameter int BUS_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     pc_valid_i,
    output logic                     pc_adv_o,
    input  logic                     flush_i,
    ysyx_22041461_if_fetch_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]      state;
    logic [XLEN-1:0] pc_lat;
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            adv;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            pop;
    logic            buf_free;
    logic [31:0]     rsp_inst;
`ifdef IF_MISALIGN_CHECK_EN
    logic            out_misalign;
    logic            misaligned;
`endif

    // Handshake helpers and instruction select
    always_comb begin
        pop      = out_valid & bus.id_ready_i;
        buf_free = ~out_valid | bus.id_ready_i;
        rsp_inst = pc_lat[2] ? bus.imem_rsp_data_i[BUS_W-1:32] : bus.imem_rsp_data_i[31:0];
`ifdef IF_MISALIGN_CHECK_EN
        misaligned = (pc_i[1:0] != 2'b00);
`endif
    end

    // Fetch FSM, request registers and output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc_lat    <= '0;
            req_valid <= 1'b0;
            req_addr  <= '0;
            adv       <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            out_misalign <= 1'b0;
`endif
        end else begin
            adv <= 1'b0;
            if (pop) begin
                out_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
                out_misalign <= 1'b0;
`endif
            end
            if (flush_i) begin
                // An accepted-but-unanswered request must still be drained.
                out_valid <= 1'b0;
                req_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
                out_misalign <= 1'b0;
`endif
                case (state)
                    ST_REQ:   state <= bus.imem_req_ready_i ? ST_DRAIN : ST_IDLE;
                    ST_WAIT:  state <= bus.imem_rsp_valid_i ? ST_IDLE : ST_DRAIN;
                    ST_DRAIN: if (bus.imem_rsp_valid_i) state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pc_valid_i && buf_free) begin
`ifdef IF_MISALIGN_CHECK_EN
                            if (misaligned) begin
                                out_valid    <= 1'b1;
                                out_pc       <= pc_i;
                                out_inst     <= 32'h0000_0013;
                                out_misalign <= 1'b1;
                                adv          <= 1'b1;
                            end else begin
                                pc_lat    <= pc_i;
                                req_valid <= 1'b1;
                                req_addr  <= {pc_i[XLEN-1:3], 3'b000};
                                state     <= ST_REQ;
                            end
`else
                            pc_lat    <= pc_i;
                            req_valid <= 1'b1;
                            req_addr  <= {pc_i[XLEN-1:3], 3'b000};
                            state     <= ST_REQ;
`endif
                        end
                    end
                    ST_REQ: begin
                        if (bus.imem_req_ready_i) begin
                            req_valid <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.imem_rsp_valid_i) begin
                            out_valid <= 1'b1;
                            out_pc    <= pc_lat;
                            out_inst  <= rsp_inst;
                            adv       <= 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
                            out_misalign <= 1'b0;
`endif
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (bus.imem_rsp_valid_i) state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Drive registered outputs
    always_comb begin
        pc_adv_o             = adv;
        bus.imem_req_valid_o = req_valid;
        bus.imem_req_addr_o  = req_addr;
        bus.id_valid_o       = out_valid;
        bus.id_pc_o          = out_pc;
        bus.id_inst_o        = out_inst;
`ifdef IF_MISALIGN_CHECK_EN
        bus.id_misalign_o    = out_misalign;
`endif
    end

endmodule

// File: tb/tb_ysyx_22041461_if_fetch.sv
// Scoreboard bench for the instruction-fetch stage: directed fetches push
// expected {pc, inst}; a negedge monitor pops and compares on each ID handshake.
module tb_ysyx_22041461_if_fetch;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        pc_valid_i;
    logic        pc_adv_o;
    logic        flush_i;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    ysyx_22041461_if_fetch_if #(.XLEN(64), .BUS_W(64)) bus ();

    ysyx_22041461_if_fetch #(.XLEN(64), .BUS_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .pc_valid_i (pc_valid_i),
        .pc_adv_o   (pc_adv_o),
        .flush_i    (flush_i),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.id_valid_o && bus.id_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %h inst %h, expected no output",
                         bus.id_pc_o, bus.id_inst_o);
            end else begin
                mon_e = sb.pop_front();
                chk("out_pc", bus.id_pc_o, mon_e.pc);
                chk("out_inst", 64'(bus.id_inst_o), 64'(mon_e.inst));
            end
        end
        if (!rst && pc_adv_o)
            chk("adv_has_valid", 64'(bus.id_valid_o), 64'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From REQ: hold ready low rd cycles, accept, respond after wd cycles
    task automatic finish_fetch(input logic [63:0] pc, input logic [63:0] data,
                                input logic [31:0] inst, input int rd, input int wd);
        int cyc = 1;
        for (int i = 0; i < rd; i++) begin
            chk("req_valid_hold", 64'(bus.imem_req_valid_o), 64'd1);
            chk("req_addr_hold", bus.imem_req_addr_o, {pc[63:3], 3'b000});
            chk("no_adv_in_req", 64'(pc_adv_o), 64'd0);
            tick();
            cyc++;
        end
        chk("req_addr", bus.imem_req_addr_o, {pc[63:3], 3'b000});
        bus.imem_req_ready_i = 1'b1;
        tick();
        cyc++;
        bus.imem_req_ready_i = 1'b0;
        chk("req_dropped", 64'(bus.imem_req_valid_o), 64'd0);
        for (int i = 0; i < wd; i++) begin
            tick();
            cyc++;
        end
        sb.push_back('{pc: pc, inst: inst});
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = data;
        tick();
        cyc++;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        chk("id_valid", 64'(bus.id_valid_o), 64'd1);
        chk("pc_adv_pulse", 64'(pc_adv_o), 64'd1);
        chk("latency", 64'(cyc), 64'(3 + rd + wd));
        tick();
        chk("pc_adv_single", 64'(pc_adv_o), 64'd0);
    endtask

    task automatic run_fetch(input logic [63:0] pc, input logic [63:0] data,
                             input logic [31:0] inst, input int rd, input int wd);
        int cyc = 0;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        do begin
            tick();
            cyc++;
        end while (!bus.imem_req_valid_o && cyc < 20);
        pc_valid_i = 1'b0;
        chk("accept_cycles", 64'(cyc), 64'd1);
        if (bus.imem_req_valid_o)
            finish_fetch(pc, data, inst, rd, wd);
    endtask

    initial begin
        rst                  = 1'b1;
        pc_i                 = '0;
        pc_valid_i           = 1'b0;
        flush_i              = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.id_ready_i       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req_valid", 64'(bus.imem_req_valid_o), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr_o, 64'd0);
        chk("rst_pc_adv", 64'(pc_adv_o), 64'd0);
        chk("rst_id_valid", 64'(bus.id_valid_o), 64'd0);
        chk("rst_id_pc", bus.id_pc_o, 64'd0);
        chk("rst_id_inst", 64'(bus.id_inst_o), 64'd0);

        // Basic fetches, low and high word
        run_fetch(64'h8000_0000, 64'h00100093_00000513, 32'h0000_0513, 0, 0);
        run_fetch(64'h8000_0004, 64'h00100093_00000513, 32'h0010_0093, 0, 0);
        run_fetch(64'h0000_0001_2345_678C, 64'hAABBCCDD_11223344, 32'hAABB_CCDD, 0, 0);
        // Memory back-pressure and slow response
        run_fetch(64'h8000_0008, 64'h11111111_22222222, 32'h2222_2222, 4, 0);
        run_fetch(64'h8000_000C, 64'h33333333_44444444, 32'h3333_3333, 0, 2);

        // ID stall: buffer full blocks new request; pop and start together
        bus.id_ready_i = 1'b0;
        run_fetch(64'h8000_0010, 64'h55555555_66666666, 32'h6666_6666, 0, 0);
        pc_i       = 64'h8000_0014;
        pc_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_no_req", 64'(bus.imem_req_valid_o), 64'd0);
            chk("stall_valid", 64'(bus.id_valid_o), 64'd1);
            chk("stall_pc", bus.id_pc_o, 64'h8000_0010);
            chk("stall_inst", 64'(bus.id_inst_o), 64'h6666_6666);
        end
        bus.id_ready_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        chk("pop_start_req", 64'(bus.imem_req_valid_o), 64'd1);
        chk("pop_start_valid", 64'(bus.id_valid_o), 64'd0);
        if (bus.imem_req_valid_o)
            finish_fetch(64'h8000_0014, 64'h77777777_88888888, 32'h7777_7777, 0, 0);

        // Flush in WAIT -> DRAIN, stale response discarded
        pc_i       = 64'h8000_0018;
        pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("drain_req_valid", 64'(bus.imem_req_valid_o), 64'd0);
        pc_i       = 64'h8000_001C;
        pc_valid_i = 1'b1;
        tick();
        chk("drain_no_req", 64'(bus.imem_req_valid_o), 64'd0);
        chk("drain_no_valid", 64'(bus.id_valid_o), 64'd0);
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 64'hDEADBEEF_DEADBEEF;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        chk("drain_discard_valid", 64'(bus.id_valid_o), 64'd0);
        chk("drain_discard_adv", 64'(pc_adv_o), 64'd0);
        chk("drain_exit_no_req", 64'(bus.imem_req_valid_o), 64'd0);
        tick();
        pc_valid_i = 1'b0;
        chk("post_drain_req", 64'(bus.imem_req_valid_o), 64'd1);
        if (bus.imem_req_valid_o)
            finish_fetch(64'h8000_001C, 64'hCAFEF00D_0BADC0DE, 32'hCAFE_F00D, 0, 0);

        // Flush in REQ without ready drops the request
        pc_i       = 64'h8000_0020;
        pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        flush_i    = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_req_drop", 64'(bus.imem_req_valid_o), 64'd0);
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 64'hDEADBEEF_DEADBEEF;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        chk("idle_rsp_ignored", 64'(bus.id_valid_o), 64'd0);
        run_fetch(64'h8000_0020, 64'h00000001_00000002, 32'h0000_0002, 0, 0);

        // Flush clears a full buffer
        bus.id_ready_i = 1'b0;
        run_fetch(64'h8000_0024, 64'h12345678_9ABCDEF0, 32'h1234_5678, 0, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_clears_buf", 64'(bus.id_valid_o), 64'd0);
        if (sb.size() != 0) void'(sb.pop_back());
        bus.id_ready_i = 1'b1;

        // Reset in WAIT, then stale response in IDLE
        pc_i       = 64'h8000_0028;
        pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 64'hDEADBEEF_DEADBEEF;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        chk("rst2_req_valid", 64'(bus.imem_req_valid_o), 64'd0);
        chk("rst2_req_addr", bus.imem_req_addr_o, 64'd0);
        chk("rst2_pc_adv", 64'(pc_adv_o), 64'd0);
        chk("rst2_id_valid", 64'(bus.id_valid_o), 64'd0);
        chk("rst2_id_pc", bus.id_pc_o, 64'd0);
        chk("rst2_id_inst", 64'(bus.id_inst_o), 64'd0);
        run_fetch(64'h8000_0000, 64'h00100093_00000513, 32'h0000_0513, 0, 0);

`ifdef IF_MISALIGN_CHECK_EN
        // Misaligned PC produces a flagged nop without a memory request
        pc_i       = 64'h8000_0102;
        pc_valid_i = 1'b1;
        sb.push_back('{pc: 64'h8000_0102, inst: 32'h0000_0013});
        tick();
        pc_valid_i = 1'b0;
        chk("mis_valid", 64'(bus.id_valid_o), 64'd1);
        chk("mis_flag", 64'(bus.id_misalign_o), 64'd1);
        chk("mis_adv", 64'(pc_adv_o), 64'd1);
        chk("mis_no_req", 64'(bus.imem_req_valid_o), 64'd0);
        tick();
        run_fetch(64'h8000_0100, 64'h00100093_00000513, 32'h0000_0513, 0, 0);
        chk("mis_flag_clear", 64'(bus.id_misalign_o), 64'd0);
`endif

        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
